sipo_fifo_buf: RTL and testbench

Parametrised serial-in/parallel-out buffer: assembles a serial bitstream into WORD_W-bit words, stores them in a DEPTH-entry circular buffer and presents them through a valid/ready parallel port. Successor to the fixed 32-bit × 64-line scan-capture buffer. Adds:
- FIFO read side with handshake;
- full/empty/occupancy status;
- sticky overflow reporting;
- synchronous flush.

It sits between the scan-chain output of the DUT wrapper and the host-side word reader.

---
 rtl/sipobuf_pkg.sv | 19 +
 rtl/sipobuf_mem.sv | 32 +++
 rtl/sipo_fifo_buf.sv | 120 ++++++++++++
 tb/tb_sipo_fifo_buf.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipobuf_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out capture buffer.
// Optional feature macro used by this block: SIPOBUF_PARITY_EN.
package sipobuf_pkg;

  localparam int SIPOBUF_WORD_W_DEF = 32;
  localparam int SIPOBUF_DEPTH_DEF  = 64;
  localparam int SIPOBUF_PAR_MAX_W  = 256;

  // Pointer width for a power-of-two depth (depth >= 2 keeps this >= 1).
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Even parity: XOR of all bits; callers zero-extend to the max width.
  function automatic logic parity(input logic [SIPOBUF_PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipobuf_mem.sv
// Word storage: simple dual-port array with synchronous write and a
// registered read port that doubles as the buffer's output register.
module sipobuf_mem
  import sipobuf_pkg::*;
#(
  parameter int DEPTH = SIPOBUF_DEPTH_DEF,
  parameter int EW    = SIPOBUF_WORD_W_DEF,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  // Only the read register is reset; the array keeps stale contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   rdata <= '0;
    else if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sipo_fifo_buf.sv
// Serial-in/parallel-out buffer: bit assembler feeding a DEPTH-entry FIFO
// with a valid/ready output register. Optional parity: SIPOBUF_PARITY_EN.
module sipo_fifo_buf
  import sipobuf_pkg::*;
#(
  parameter int WORD_W = SIPOBUF_WORD_W_DEF,
  parameter int DEPTH  = SIPOBUF_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       flush,
  output logic [WORD_W-1:0]          pout,
  output logic                       pout_valid,
  input  logic                       pout_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(WORD_W)-1:0]  bit_cnt,
  output logic                       overflow
`ifdef SIPOBUF_PARITY_EN
  ,
  output logic                       pout_par
`endif
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(WORD_W);
`ifdef SIPOBUF_PARITY_EN
  localparam int EW = WORD_W + 1;
`else
  localparam int EW = WORD_W;
`endif

  logic [WORD_W-1:0] asm_q;
  logic [BW-1:0]     bit_q;
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt_q;
  logic              vld_q, ovf_q;

  logic              word_done, full_w, empty_w, wr, fetch;
  logic [WORD_W-1:0] word;
  logic [EW-1:0]     wdata, rdata;

  assign word_done = sin_valid && (bit_q == BW'(WORD_W - 1));
  assign word      = {asm_q[WORD_W-2:0], sin};
  assign full_w    = (cnt_q == CW'(DEPTH));
  assign empty_w   = (cnt_q == '0);

  // Status is taken before the edge, so a word completing while full is
  // dropped even if a fetch frees a slot on the same edge.
  assign wr    = !flush && word_done && !full_w;
  assign fetch = !flush && (!vld_q || pout_ready) && !empty_w;

`ifdef SIPOBUF_PARITY_EN
  assign wdata = {parity(SIPOBUF_PAR_MAX_W'(word)), word};
`else
  assign wdata = word;
`endif

  sipobuf_mem #(.DEPTH(DEPTH), .EW(EW), .AW(AW)) u_mem (
    .clk   (clk),
    .reset (reset),
    .wen   (wr),
    .waddr (wptr),
    .wdata (wdata),
    .ren   (fetch),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q <= '0;
      bit_q <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (flush) begin
      asm_q <= '0;
      bit_q <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (sin_valid) begin
        asm_q <= word;
        bit_q <= word_done ? '0 : bit_q + BW'(1);
      end
      if (word_done && full_w) ovf_q <= 1'b1;
      if (wr)    wptr <= wptr + AW'(1);
      if (fetch) rptr <= rptr + AW'(1);
      case ({wr, fetch})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (fetch)           vld_q <= 1'b1;
      else if (pout_ready) vld_q <= 1'b0;
    end
  end

  assign pout       = rdata[WORD_W-1:0];
  assign pout_valid = vld_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = cnt_q;
  assign bit_cnt    = bit_q;
  assign overflow   = ovf_q;
`ifdef SIPOBUF_PARITY_EN
  assign pout_par   = rdata[WORD_W];
`endif

endmodule

// File: tb/tb_sipo_fifo_buf.sv
// Bench for sipo_fifo_buf (WORD_W=8, DEPTH=4): queue-based reference model,
// per-cycle compare, directed scenarios plus a randomized soak.
module tb_sipo_fifo_buf;
  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sin, sin_valid, flush, pout_ready;
  logic [W-1:0] pout;
  logic       pout_valid, full, empty, overflow;
  logic [2:0] count;
  logic [2:0] bit_cnt;
`ifdef SIPOBUF_PARITY_EN
  logic       pout_par;
`endif

  sipo_fifo_buf #(.WORD_W(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .flush      (flush),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .bit_cnt    (bit_cnt),
    .overflow   (overflow)
`ifdef SIPOBUF_PARITY_EN
    ,
    .pout_par   (pout_par)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: memory as a queue, output register as a word + flag.
  logic [W-1:0] q [$];
  logic [W-1:0] m_asm;
  int           m_nb;
  logic         m_ov;
  logic [W-1:0] m_ow;
  logic         m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_asm = '0; m_nb = 0; m_ov = 1'b0; m_ow = '0; m_ovf = 1'b0;
  endtask

  task automatic model_update();
    bit was_full, was_empty;
    if (flush) begin
      q.delete();
      m_asm = '0; m_nb = 0; m_ov = 1'b0; m_ovf = 1'b0;
      return;
    end
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if ((!m_ov || pout_ready) && !was_empty) begin
      m_ow = q.pop_front();
      m_ov = 1'b1;
    end else if (m_ov && pout_ready) begin
      m_ov = 1'b0;
    end
    if (sin_valid) begin
      m_asm = {m_asm[W-2:0], sin};
      if (m_nb == W - 1) begin
        m_nb = 0;
        if (was_full) m_ovf = 1'b1;
        else          q.push_back(m_asm);
      end else begin
        m_nb++;
      end
    end
  endtask

  task automatic compare();
    chk("pout",       32'(pout),       32'(m_ow));
    chk("pout_valid", 32'(pout_valid), 32'(m_ov));
    chk("count",      32'(count),      32'(q.size()));
    chk("full",       32'(full),       32'(q.size() == D));
    chk("empty",      32'(empty),      32'(q.size() == 0));
    chk("bit_cnt",    32'(bit_cnt),    32'(m_nb));
    chk("overflow",   32'(overflow),   32'(m_ovf));
`ifdef SIPOBUF_PARITY_EN
    chk("pout_par",   32'(pout_par),   32'(^m_ow));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1 compare();
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int from, input int to);
    for (int i = from; i >= to; i--) begin
      sin = w[i]; sin_valid = 1'b1;
      step();
    end
    sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_bits(w, W - 1, 0);
  endtask

  initial begin
    reset = 1'b0; sin = 1'b0; sin_valid = 1'b0; flush = 1'b0; pout_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pout_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_pout",  32'(pout), 0);
    compare();
    reset = 1'b1;

    // Single word, MSB first
    send_word(8'hA5);
    chk("single_cnt_mem", 32'(count), 1);
    chk("single_notvld",  32'(pout_valid), 0);
    idle(1);
    chk("single_pout",  32'(pout), 32'h A5);
    chk("single_vld",   32'(pout_valid), 1);
    chk("single_empty", 32'(empty), 1);

    // Pop, then gapped word
    pout_ready = 1'b1; idle(1); pout_ready = 1'b0;
    send_bits(8'h3C, 7, 5);
    idle(3);
    chk("gap_bitcnt", 32'(bit_cnt), 3);
    send_bits(8'h3C, 4, 0);
    idle(1);
    chk("gap_pout", 32'(pout), 32'h3C);

    // Fill and overflow
    pout_ready = 1'b1; idle(1); pout_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send_word(8'(k));
    chk("fill_pout", 32'(pout), 1);
    chk("fill_cnt",  32'(count), 4);
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf",  32'(overflow), 1);
    for (int k = 1; k <= 5; k++) begin
      chk("pop_seq", 32'(pout), 32'(k));
      chk("pop_vld", 32'(pout_valid), 1);
      pout_ready = 1'b1; idle(1);
    end
    pout_ready = 1'b0;
    chk("drain_vld",   32'(pout_valid), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf",   32'(overflow), 1);

    // Streaming
    flush = 1'b1; idle(1); flush = 1'b0;
    chk("flush_ovf", 32'(overflow), 0);
    pout_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sin = 1'($urandom); sin_valid = 1'b1;
      step();
      chk("stream_cnt_le1", 32'(count <= 1), 1);
    end
    sin_valid = 1'b0; idle(3);

    // Flush mid-word with two words stored
    pout_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_word(8'($urandom));
    send_bits(8'hFF, 7, 3);
    chk("pre_flush_cnt", 32'(count), 2);
    flush = 1'b1; idle(1); flush = 1'b0;
    chk("flush_cnt",    32'(count), 0);
    chk("flush_bitcnt", 32'(bit_cnt), 0);
    chk("flush_vld",    32'(pout_valid), 0);
    chk("flush_empty",  32'(empty), 1);
    send_word(8'h5A);
    idle(1);
    chk("postflush_pout", 32'(pout), 32'h5A);
    chk("postflush_vld",  32'(pout_valid), 1);

    // Randomized soak with varying consumer pressure
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 300; i++) begin
        sin        = 1'($urandom);
        sin_valid  = ($urandom_range(3) != 0);
        pout_ready = ($urandom_range(5) < seg);
        flush      = ($urandom_range(99) == 0);
        step();
      end
    end
    flush = 1'b0; pout_ready = 1'b0;

    // Asynchronous reset between edges
    send_word(8'h11);
    send_bits(8'hF0, 7, 5);
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_pout",   32'(pout), 0);
    chk("arst_bitcnt", 32'(bit_cnt), 0);
    chk("arst_vld",    32'(pout_valid), 0);
    chk("arst_empty",  32'(empty), 1);
    compare();
    #1 reset = 1'b1;
    send_word(8'h07);
    idle(1);
    chk("after_arst_pout", 32'(pout), 32'h07);
`ifdef SIPOBUF_PARITY_EN
    chk("par_07", 32'(pout_par), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected end of stimulus");
    $fatal(1);
  end

endmodule
